// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing the async FIFO write port among N_REQ requesters.
// Define FIFO_ARB_STATS_EN to add per-requester saturating accepted-word counters (stat_words).
module fifo_wr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rstp,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   write,
    output logic [WIDTH-1:0]       w_data,
    input  logic                   w_full,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]    stat_words
`endif
);

    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);
    localparam logic [OW:0]   N_REQ_W    = (OW + 1)'(N_REQ);
    localparam logic [OW-1:0] LAST_IDX   = OW'(N_REQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              busy_q, busy_d;

    logic [N_REQ-1:0]  rot_c;
    logic [OW-1:0]     rot_pos_c;
    logic [OW:0]       pick_sum_c;
    logic [OW-1:0]     pick_idx_c;
    logic [OW-1:0]     owner_next_c;
    logic              burst_hit_c;
    logic              accept_c;

    // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_c     = N_REQ'({req_valid, req_valid} >> rr_ptr_q);
        rot_pos_c = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                rot_pos_c = OW'(k);
            end
        end
        pick_sum_c = {1'b0, rr_ptr_q} + {1'b0, rot_pos_c};
        if (pick_sum_c >= N_REQ_W) begin
            pick_sum_c = pick_sum_c - N_REQ_W;
        end
        pick_idx_c = pick_sum_c[OW-1:0];
    end

    assign owner_next_c = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
    assign burst_hit_c  = (MAX_BURST != 0) && (burst_cnt_q == BURST_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rstp) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    // Next state, write-port handshake and registered grant/busy targets
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        accept_c    = 1'b0;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    state_d     = S_GRANT;
                    owner_d     = pick_idx_c;
                    burst_cnt_d = '0;
                end
            end
            S_GRANT: begin
                req_ready[owner_q] = ~w_full;
                accept_c           = req_valid[owner_q] & ~w_full;
                if (accept_c) begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                    if (req_last[owner_q] || burst_hit_c) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = owner_next_c;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d == S_GRANT);
        grant_d = '0;
        if (state_d == S_GRANT) begin
            grant_d[owner_d] = 1'b1;
        end
    end

    assign write  = accept_c;
    assign w_data = req_data[int'(owner_q) * int'(WIDTH) +: WIDTH];
    assign grant  = grant_q;
    assign busy   = busy_q;

`ifdef FIFO_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] stat_q;

    // Saturating accepted-word count per requester
    always_ff @(posedge clk) begin
        if (rstp) begin
            stat_q <= '0;
        end else if (accept_c && (stat_q[owner_q] != 32'hFFFF_FFFF)) begin
            stat_q[owner_q] <= stat_q[owner_q] + 32'd1;
        end
    end

    assign stat_words = stat_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO (write / w_data / w_full) between N_REQ requesters in the write clock domain.
- Round-robin, packet-locked arbitration: a granted requester keeps the port until its last word is accepted or a burst limit expires.
- Sits directly in front of the FIFO write side and is clocked by the FIFO write clock.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, data width; equals FIFO WIDTH
- MAX_BURST, 16, max words per grant before forced release; 0 = unlimited (release only on last)

Ports:
- clk  in  1  write-domain clock (FIFO w_clk)
- rstp  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester word valid
- req_data  in  N_REQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH]
- req_last  in  N_REQ  marks the final word of a packet
- req_ready  out  N_REQ  word accepted when req_valid[i] & req_ready[i]
- write  out  1  to FIFO write
- w_data  out  WIDTH  to FIFO w_data
- w_full  in  1  from FIFO w_full
- grant  out  N_REQ  one-hot current owner; all zero in IDLE
- busy  out  1  high in GRANT state

Behaviour:
- Interface: one clock, clk. Reset rstp is synchronous and active-high.
- Reset values:
  - State=IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - grant=0, busy=0, req_ready=0, write=0.
  - w_data is a don't-care, driven from owner 0's slice.
- FSM, two states:
  - IDLE:
    - If any req_valid is high, select the first set bit scanning rr_ptr, rr_ptr+1, … mod N_REQ.
    - Register it as owner and go to GRANT. burst_cnt<=0.
    - One cycle of arbitration latency; no word is accepted in IDLE.
  - GRANT:
    - req_ready[owner] = ~w_full. All other req_ready = 0.
    - write = req_valid[owner] & ~w_full (combinational, zero latency).
    - w_data = req_data slice of owner.
    - accept = write.
    - On accept, burst_cnt++.
  - Release, from GRANT to IDLE, on any accept where:
    - req_last[owner]=1, or
    - MAX_BURST!=0 and burst_cnt==MAX_BURST-1.
  - On release, rr_ptr <= (owner+1) mod N_REQ.
- Back-to-back packets always take one idle bubble cycle (IDLE).
- Owner deasserts req_valid mid-packet: grant is held indefinitely, write=0, no timeout.
- w_full high: no accept, no state or counter change. Resumes in the cycle w_full falls.
- A requester that is not granted never sees req_ready; its data is ignored.
- A single-word packet (last on the first word) releases after one accept.
- A packet longer than MAX_BURST:
  - It is split; the owner loses the grant after MAX_BURST words.
  - Its remaining words re-arbitrate round-robin.
  - No marker is inserted in the FIFO.
- rstp asserted mid-packet:
  - All state returns to reset values next edge.
  - A partially written packet stays in the FIFO. Upstream discards it.
- burst_cnt width is clog2(MAX_BURST)+1. With MAX_BURST=0 the counter is unused.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- When defined:
  - Adds output port stat_words, N_REQ*32 bits. Counter i occupies bits [i*32 +: 32].
  - Counter i increments on each accept from requester i and saturates at 0xFFFF_FFFF.
  - Cleared by rstp.
- When undefined: port and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=4'b0100 with a 3-word packet, last on word 3, w_full=0:
  - grant=4'b0100 one cycle after valid.
  - write high 3 consecutive cycles, with w_data matching requester 2's words.
  - Then IDLE with grant=0; rr_ptr=3.
- All 4 requesters continuously valid, each sending 1-word packets:
  - Grant order 0,1,2,3,0.
  - Each grant separated by exactly one IDLE cycle.
- Requester 1 sends a 20-word packet with MAX_BURST=16 while requester 2 is also valid:
  - 16 words accepted from requester 1, then requester 2's packet, then requester 1's remaining 4 words.
- w_full raised for 5 cycles in the middle of a granted packet:
  - write=0 and req_ready=0 for those 5 cycles.
  - burst_cnt frozen; no word lost or duplicated.
- rstp pulsed for 1 cycle while requester 3 is mid-packet:
  - Next cycle grant=0, busy=0, write=0.
  - Subsequent arbitration starts from requester 0.
- FIFO_ARB_STATS_EN defined, requester 0 sends 7 words and requester 2 sends 2 words:
  - stat_words slices are 7, 0, 2, 0.
  - All slices are 0 after rstp.
